// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Baud selection, FSM states and receive-buffer depth.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_select_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned FIFO_DEPTH = 64;

  function automatic int unsigned baud_divisor(
    input int unsigned  clock_frequency,
    input baud_select_t select
  );
    int unsigned baud;
    baud = 9600;
    case (select)
      BAUD_9600:   baud = 9600;
      BAUD_19200:  baud = 19200;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return clock_frequency / baud;
  endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// uart_receiver_fifo: first-word-fall-through receive buffer.
// Head is visible combinationally; it reads as 0 when empty.
module uart_receiver_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? 8'h00 : mem[rd_ptr];

  // Storage array, no reset needed since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with selectable baud rate.
// Bytes land in a FWFT buffer; errors are one-cycle pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned FIFO_DEPTH      = uart_pkg::FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       read_enable,
  input  logic [5:0] buffer_full_threshold,
  input  logic [1:0] baudrate_select,
  output logic [7:0] data_out,
  output logic       buffer_empty,
  output logic       buffer_full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned DIV0 = baud_divisor(CLOCK_FREQUENCY, BAUD_9600);
  localparam int unsigned DIV1 = baud_divisor(CLOCK_FREQUENCY, BAUD_19200);
  localparam int unsigned DIV2 = baud_divisor(CLOCK_FREQUENCY, BAUD_57600);
  localparam int unsigned DIV3 = baud_divisor(CLOCK_FREQUENCY, BAUD_115200);
  localparam int unsigned CW   = $clog2(DIV0);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  function automatic logic [CW-1:0] full_load(input logic [1:0] sel);
    case (sel)
      2'd0:    return CW'(DIV0 - 1);
      2'd1:    return CW'(DIV1 - 1);
      2'd2:    return CW'(DIV2 - 1);
      default: return CW'(DIV3 - 1);
    endcase
  endfunction

  function automatic logic [CW-1:0] half_load(input logic [1:0] sel);
    case (sel)
      2'd0:    return CW'(DIV0 / 2 - 1);
      2'd1:    return CW'(DIV1 / 2 - 1);
      2'd2:    return CW'(DIV2 / 2 - 1);
      default: return CW'(DIV3 / 2 - 1);
    endcase
  endfunction

  rx_state_t     state;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_index;
  logic [7:0]    shreg;
  logic          sync1;
  logic          rx;
  logic          rx_prev;
  logic          tick;
  logic          push_req;
  logic [AW:0]   fifo_count;
  logic          fifo_full;

  assign tick     = (cnt == '0);
  assign push_req = (state == STOP) && tick && rx;
  assign buffer_full = fifo_count >= (AW+1)'(buffer_full_threshold);

  // Two-flop synchronizer plus previous sample for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= data_in;
      rx      <= sync1;
      rx_prev <= rx;
    end
  end

  // Frame FSM with bit-period down-counter and registered pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= '0;
      cnt         <= '0;
      bit_index   <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (!tick) cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
          if (rx_prev && !rx) begin
            sel_q <= baudrate_select;
            cnt   <= half_load(baudrate_select);
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rx) begin
              cnt       <= full_load(sel_q);
              bit_index <= '0;
              state     <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx, shreg[7:1]};
            cnt   <= full_load(sel_q);
            if (bit_index == 3'd7) state <= STOP;
            else bit_index <= bit_index + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (!rx) frame_error <= 1'b1;
            else if (fifo_full && !read_enable) overrun <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_receiver_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (shreg),
    .pop       (read_enable),
    .head_data (data_out),
    .count     (fifo_count),
    .empty     (buffer_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized scenarios against a queue model.
// Frames are driven bit by bit at the selected bit period.
module tb_uart_receiver;

  localparam int unsigned CLK_HZ = 1_843_200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b1;
  logic       read_enable = 1'b0;
  logic [5:0] buffer_full_threshold = 6'd0;
  logic [1:0] baudrate_select = 2'd3;
  logic [7:0] data_out;
  logic       buffer_empty;
  logic       buffer_full;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int fe_cycles = 0;
  int fe_events = 0;
  int ov_cycles = 0;
  int ov_events = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [7:0] q[$];

  uart_receiver #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .FIFO_DEPTH      (64)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .data_in               (data_in),
    .read_enable           (read_enable),
    .buffer_full_threshold (buffer_full_threshold),
    .baudrate_select       (baudrate_select),
    .data_out              (data_out),
    .buffer_empty          (buffer_empty),
    .buffer_full           (buffer_full),
    .frame_error           (frame_error),
    .overrun               (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    fe_prev <= frame_error;
    ov_prev <= overrun;
    if (frame_error) fe_cycles <= fe_cycles + 1;
    if (overrun) ov_cycles <= ov_cycles + 1;
    if (frame_error && !fe_prev) fe_events <= fe_events + 1;
    if (overrun && !ov_prev) ov_events <= ov_events + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bit_period(input int s);
    int baud;
    case (s)
      0: baud = 9600;
      1: baud = 19200;
      2: baud = 57600;
      default: baud = 115200;
    endcase
    return CLK_HZ / baud;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int d,
                            input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      data_in = f[i];
      tick_n(d);
    end
  endtask

  task automatic pop_one();
    read_enable = 1'b1;
    tick_n(1);
    read_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    buffer_full_threshold = 6'd0;
    tick_n(3);
    n_checks++;
    if (buffer_empty !== 1'b1 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_buf: empty=%b data=%h want 1/00",
               buffer_empty, data_out);
    end
    n_checks++;
    if (frame_error !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: fe=%b ov=%b want 0/0",
               frame_error, overrun);
    end
    n_checks++;
    if (buffer_full !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_full_thr0: got %b want 1", buffer_full);
    end
    buffer_full_threshold = 6'd5;
    #1;
    n_checks++;
    if (buffer_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_full_thr5: got %b want 0", buffer_full);
    end
    tick_n(1);
    reset = 1'b0;
    tick_n(4);
  endtask

  task automatic test_single_byte();
    int d, tgt;
    baudrate_select = 2'd3;
    d = bit_period(3);
    tgt = int'(cyc) + 3 + d / 2 + 9 * d;
    fork
      send_frame(8'hA5, d, 1'b1);
      begin
        while (int'(cyc) < tgt - 1) tick_n(1);
        n_checks++;
        if (buffer_empty !== 1'b1) begin
          n_fail++;
          $display("FAIL single_pre: empty=%b want 1", buffer_empty);
        end
        tick_n(1);
        n_checks++;
        if (buffer_empty !== 1'b0 || data_out !== 8'hA5) begin
          n_fail++;
          $display("FAIL single_push: empty=%b data=%h want 0/a5",
                   buffer_empty, data_out);
        end
      end
    join
    pop_one();
    n_checks++;
    if (buffer_empty !== 1'b1 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL single_pop: empty=%b data=%h want 1/00",
               buffer_empty, data_out);
    end
  endtask

  task automatic test_all_baud();
    logic [7:0] r;
    int fe0, ov0;
    for (int s = 0; s < 4; s++) begin
      baudrate_select = 2'(s);
      r = 8'($urandom);
      send_frame(8'h3C, bit_period(s), 1'b1);
      q.push_back(8'h3C);
      send_frame(r, bit_period(s), 1'b1);
      q.push_back(r);
      tick_n(3);
      while (q.size() > 0) begin
        n_checks++;
        if (buffer_empty !== 1'b0 || data_out !== q[0]) begin
          n_fail++;
          $display("FAIL baud%0d: empty=%b data=%h want 0/%h",
                   s, buffer_empty, data_out, q[0]);
        end
        void'(q.pop_front());
        pop_one();
      end
    end
    fe0 = fe_events;
    ov0 = ov_events;
    data_in = 1'b0;
    tick_n(1);
    data_in = 1'b1;
    tick_n(bit_period(3) * 2 + 5);
    n_checks++;
    if (buffer_empty !== 1'b1 || fe_events != fe0 || ov_events != ov0)
    begin
      n_fail++;
      $display("FAIL glitch: empty=%b fe=%0d ov=%0d want 1/%0d/%0d",
               buffer_empty, fe_events, ov_events, fe0, ov0);
    end
  endtask

  task automatic test_frame_error();
    int d, fc0, fe0;
    baudrate_select = 2'd2;
    d = bit_period(2);
    fc0 = fe_cycles;
    fe0 = fe_events;
    send_frame(8'h55, d, 1'b0);
    tick_n(3 * d);
    n_checks++;
    if (fe_events - fe0 != 1 || fe_cycles - fc0 != 1) begin
      n_fail++;
      $display("FAIL frame_err_pulse: events=%0d cycles=%0d want 1/1",
               fe_events - fe0, fe_cycles - fc0);
    end
    n_checks++;
    if (buffer_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err_nopush: empty=%b want 1", buffer_empty);
    end
    data_in = 1'b1;
    tick_n(d);
    send_frame(8'h0F, d, 1'b1);
    tick_n(2);
    n_checks++;
    if (buffer_empty !== 1'b0 || data_out !== 8'h0F) begin
      n_fail++;
      $display("FAIL frame_err_next: empty=%b data=%h want 0/0f",
               buffer_empty, data_out);
    end
    pop_one();
  endtask

  task automatic test_overrun_threshold();
    int d, ov0, oc0;
    baudrate_select = 2'd3;
    buffer_full_threshold = 6'd4;
    d = bit_period(3);
    for (int i = 0; i < 64; i++) begin
      send_frame(8'(i), d, 1'b1);
      q.push_back(8'(i));
      if (i == 2 || i == 3) begin
        n_checks++;
        if (buffer_full !== (q.size() >= 4)) begin
          n_fail++;
          $display("FAIL threshold_n%0d: got %b want %b",
                   q.size(), buffer_full, q.size() >= 4);
        end
      end
    end
    ov0 = ov_events;
    oc0 = ov_cycles;
    send_frame(8'($urandom), d, 1'b1);
    tick_n(2);
    n_checks++;
    if (ov_events - ov0 != 1 || ov_cycles - oc0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: events=%0d cycles=%0d want 1/1",
               ov_events - ov0, ov_cycles - oc0);
    end
  endtask

  task automatic test_push_pop_full();
    int d, tgt, ov0;
    d = bit_period(3);
    ov0 = ov_events;
    tgt = int'(cyc) + 3 + d / 2 + 9 * d;
    fork
      send_frame(8'h77, d, 1'b1);
      begin
        while (int'(cyc) < tgt - 1) tick_n(1);
        n_checks++;
        if (data_out !== q[0]) begin
          n_fail++;
          $display("FAIL full_head: got %h want %h", data_out, q[0]);
        end
        pop_one();
      end
    join
    void'(q.pop_front());
    q.push_back(8'h77);
    tick_n(2);
    n_checks++;
    if (ov_events != ov0) begin
      n_fail++;
      $display("FAIL full_pushpop_ov: events=%0d want %0d",
               ov_events, ov0);
    end
    while (q.size() > 0) begin
      n_checks++;
      if (buffer_empty !== 1'b0 || data_out !== q[0]) begin
        n_fail++;
        $display("FAIL drain_%0d: empty=%b data=%h want 0/%h",
                 q.size(), buffer_empty, data_out, q[0]);
      end
      void'(q.pop_front());
      pop_one();
    end
    n_checks++;
    if (buffer_empty !== 1'b1 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_end: empty=%b data=%h want 1/00",
               buffer_empty, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int d, n;
    logic [7:0] b;
    d = bit_period(2);
    n = 5;
    buffer_full_threshold = 6'($urandom_range(1, 6));
    baudrate_select = 2'd2;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fork
        send_frame(b, d, 1'b1);
        begin
          tick_n(d);
          baudrate_select = 2'($urandom);
          tick_n(7 * d);
          baudrate_select = 2'd2;
        end
      join
      q.push_back(b);
    end
    tick_n(2);
    n_checks++;
    if (buffer_full !== (q.size() >= int'(buffer_full_threshold))) begin
      n_fail++;
      $display("FAIL b2b_full: got %b thr=%0d n=%0d",
               buffer_full, buffer_full_threshold, q.size());
    end
    while (q.size() > 0) begin
      n_checks++;
      if (buffer_empty !== 1'b0 || data_out !== q[0]) begin
        n_fail++;
        $display("FAIL b2b_data: empty=%b data=%h want 0/%h",
                 buffer_empty, data_out, q[0]);
      end
      void'(q.pop_front());
      pop_one();
    end
  endtask

  task automatic test_reset_mid_frame();
    int d, tgt;
    baudrate_select = 2'd3;
    d = bit_period(3);
    send_frame(8'h5A, d, 1'b1);
    q.push_back(8'h5A);
    tgt = int'(cyc) + 3 + d / 2 + 4 * d + d / 2;
    fork
      send_frame(8'($urandom), d, 1'b1);
      begin
        while (int'(cyc) < tgt) tick_n(1);
        reset = 1'b1;
        #1;
        n_checks++;
        if (buffer_empty !== 1'b1 || data_out !== 8'h00 ||
            frame_error !== 1'b0 || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset: empty=%b data=%h fe=%b ov=%b",
                   buffer_empty, data_out, frame_error, overrun);
        end
      end
    join
    q.delete();
    tick_n(1);
    reset = 1'b0;
    tick_n(5);
    send_frame(8'hC3, d, 1'b1);
    tick_n(2);
    n_checks++;
    if (buffer_empty !== 1'b0 || data_out !== 8'hC3) begin
      n_fail++;
      $display("FAIL after_reset: empty=%b data=%h want 0/c3",
               buffer_empty, data_out);
    end
    pop_one();
    n_checks++;
    if (buffer_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_pop: empty=%b want 1", buffer_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_all_baud();
    test_frame_error();
    test_overrun_threshold();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
